layer_norm_row_feeder: RTL



---
 rtl/layer_norm_row_feeder_pkg.sv | 19 +
 rtl/layer_norm_row_buffer.sv | 48 ++++
 rtl/layer_norm_row_feeder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/layer_norm_row_feeder_pkg.sv
// Shared defaults, FSM encoding and element-slice helper for the LayerNorm row feeder.
package layer_norm_row_feeder_pkg;

  localparam int unsigned DEFAULT_MATRIX_SIZE = 64;
  localparam int unsigned DEFAULT_X_WIDTH     = 16;
  localparam int unsigned DEFAULT_LANES       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

  // LSB position of element idx in a flat row of width-bit elements
  function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/layer_norm_row_buffer.sv
// One row register filled a beat at a time, with a full flag for ping-pong hand-off.
module layer_norm_row_buffer
  import layer_norm_row_feeder_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
  parameter int unsigned X_WIDTH     = DEFAULT_X_WIDTH,
  parameter int unsigned LANES       = DEFAULT_LANES,
  parameter int unsigned BEAT_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [BEAT_W-1:0]              wr_beat,
  input  logic [LANES*X_WIDTH-1:0]       wr_data,
  input  logic                           set_full,
  input  logic                           clr_full,
  output logic                           full,
  output logic [MATRIX_SIZE*X_WIDTH-1:0] row_data
);

  localparam int unsigned BEATS     = MATRIX_SIZE / LANES;
  localparam int unsigned BEAT_BITS = LANES * X_WIDTH;

  // Write all lanes of the addressed beat into their element slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_data <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (wr_beat == BEAT_W'(b)) begin
          row_data[elem_lsb(b * LANES, X_WIDTH) +: BEAT_BITS] <= wr_data;
        end
      end
    end
  end

  // Full flag: set when the last beat lands, cleared when the row is consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/layer_norm_row_feeder.sv
// Assembles lane-parallel input beats into rows and issues them to the row LayerNorm
// processor through a ping-pong buffer so the next row fills while one is processed.
module layer_norm_row_feeder
  import layer_norm_row_feeder_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
  parameter int unsigned X_WIDTH     = DEFAULT_X_WIDTH,
  parameter int unsigned LANES       = DEFAULT_LANES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_matrix,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*X_WIDTH-1:0]       in_data,
  output logic [MATRIX_SIZE*X_WIDTH-1:0] row_x_out,
  output logic                           row_start_out,
  input  logic                           row_done_in,
  output logic [5:0]                     row_index_out,
  output logic                           matrix_done,
  output logic                           busy
);

  localparam int unsigned BEATS  = MATRIX_SIZE / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = $clog2(MATRIX_SIZE + 1);

  feeder_state_e state, state_d;
  logic              wr_sel, wr_sel_d;
  logic              rd_sel, rd_sel_d;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_d;
  logic [CNT_W-1:0]  rows_written, rows_written_d;
  logic [CNT_W-1:0]  rows_issued, rows_issued_d;
  logic              waiting, waiting_d;
  logic              row_start_d;
  logic [5:0]        row_index_d;
  logic              wr_en;
  logic              beat_accept;
  logic [1:0]        set_full;
  logic [1:0]        clr_full;
  logic [1:0]        full;
  logic [MATRIX_SIZE*X_WIDTH-1:0] row_buf_data [2];

  assign in_ready    = (state == ST_RUN) && !full[wr_sel] && (rows_written < CNT_W'(MATRIX_SIZE));
  assign beat_accept = in_valid && in_ready;

  // Ping-pong row buffers; only the buffer selected by wr_sel takes beats
  for (genvar g = 0; g < 2; g++) begin : g_buf
    layer_norm_row_buffer #(
      .MATRIX_SIZE(MATRIX_SIZE),
      .X_WIDTH    (X_WIDTH),
      .LANES      (LANES),
      .BEAT_W     (BEAT_W)
    ) u_row_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en && (wr_sel == 1'(g))),
      .wr_beat (beat_cnt),
      .wr_data (in_data),
      .set_full(set_full[g]),
      .clr_full(clr_full[g]),
      .full    (full[g]),
      .row_data(row_buf_data[g])
    );
  end

  // Next-state logic for the FSM, write pointer side and read/issue side
  always_comb begin
    state_d        = state;
    wr_sel_d       = wr_sel;
    rd_sel_d       = rd_sel;
    beat_cnt_d     = beat_cnt;
    rows_written_d = rows_written;
    rows_issued_d  = rows_issued;
    waiting_d      = waiting;
    row_start_d    = 1'b0;
    row_index_d    = row_index_out;
    wr_en          = 1'b0;
    set_full       = 2'b00;
    clr_full       = 2'b00;

    case (state)
      ST_IDLE: begin
        if (start_matrix) begin
          state_d        = ST_RUN;
          wr_sel_d       = 1'b0;
          rd_sel_d       = 1'b0;
          beat_cnt_d     = '0;
          rows_written_d = '0;
          rows_issued_d  = '0;
          waiting_d      = 1'b0;
          row_index_d    = '0;
          clr_full       = 2'b11;
        end
      end
      ST_RUN: begin
        if (beat_accept) begin
          wr_en = 1'b1;
          if (beat_cnt == BEAT_W'(BEATS - 1)) begin
            beat_cnt_d       = '0;
            set_full[wr_sel] = 1'b1;
            wr_sel_d         = ~wr_sel;
            rows_written_d   = rows_written + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt + 1'b1;
          end
        end

        if (waiting && row_done_in) begin
          clr_full[rd_sel] = 1'b1;
          rd_sel_d         = ~rd_sel;
          rows_issued_d    = rows_issued + 1'b1;
          waiting_d        = 1'b0;
          if (rows_issued == CNT_W'(MATRIX_SIZE - 1)) begin
            state_d = ST_DONE;
          end
        end else if (!waiting && full[rd_sel]) begin
          row_start_d = 1'b1;
          waiting_d   = 1'b1;
          row_index_d = 6'(rows_issued);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      beat_cnt     <= '0;
      rows_written <= '0;
      rows_issued  <= '0;
      waiting      <= 1'b0;
    end else begin
      state        <= state_d;
      wr_sel       <= wr_sel_d;
      rd_sel       <= rd_sel_d;
      beat_cnt     <= beat_cnt_d;
      rows_written <= rows_written_d;
      rows_issued  <= rows_issued_d;
      waiting      <= waiting_d;
    end
  end

  // Registered processor-facing outputs; row_x_out follows the read buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_start_out <= 1'b0;
      row_index_out <= '0;
      matrix_done   <= 1'b0;
      busy          <= 1'b0;
      row_x_out     <= '0;
    end else begin
      row_start_out <= row_start_d;
      row_index_out <= row_index_d;
      matrix_done   <= (state_d == ST_DONE);
      busy          <= (state_d == ST_RUN);
      row_x_out     <= row_buf_data[rd_sel];
    end
  end

endmodule
